io_bus_ctrl: RTL and testbench
==============================

IO_BUS_CTRL -- requirements
Module: io_bus_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 16, meaning max cycles the SLOW state waits for slv_ack before it flags a bus error.
REQ-002 Parameter FAST_LAT, default 1, meaning fixed strobe-to-capture latency in cycles for on-chip targets (1..15).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 cpu_req  input  1  CPU access request; held high by CPU until cpu_ready.
REQ-006 cpu_we  input  1  1 = write, 0 = read; sampled with cpu_req.
REQ-007 cpu_addr  input  32  byte address; sampled with cpu_req.
REQ-008 cpu_wdata  input  32  write data; sampled with cpu_req.
REQ-009 dec_fast  input  1  address decoder: target is TEXTS/DATAS/BIOS/regs/textRAM/graphRAM/dmaRAM.
REQ-010 dec_dram  input  1  address decoder: target is DRAM (variable latency, acknowledged).
REQ-011 dec_others  input  1  address decoder: unmapped address.
REQ-012 slv_stb  output  1  slave strobe.
REQ-013 slv_we  output  1  registered copy of cpu_we.
REQ-014 slv_addr  output  32  registered copy of cpu_addr.
REQ-015 slv_wdata  output  32  registered copy of cpu_wdata.
REQ-016 slv_rdata  input  32  slave read data.
REQ-017 slv_ack  input  1  DRAM completion; ignored outside SLOW.
REQ-018 cpu_rdata  output  32  registered read data to CPU.
REQ-019 cpu_ready  output  1  one-cycle completion pulse.
REQ-020 bus_err  output  1  one-cycle error pulse, coincident with cpu_ready.
REQ-021 err_count  output  8  saturating count of bus errors.

Function
REQ-022 FSM states: IDLE, FAST, SLOW, RESP, ERR; exactly one active.
REQ-023 IDLE with cpu_req=1: latch we/addr/wdata into slv_* registers; decode priority dec_others > dec_dram > dec_fast; no decode bit high counts as dec_others.
REQ-024 IDLE transitions: others -> ERR; dram -> SLOW; fast -> FAST; cpu_req=0 -> stay IDLE.
REQ-025 slv_stb is 1 in every cycle spent in FAST or SLOW and 0 otherwise.
REQ-026 FAST: wait counter counts FAST_LAT cycles; on the last cycle capture slv_rdata (reads) into cpu_rdata; next state RESP.
REQ-027 SLOW: counter increments each cycle; slv_ack=1 captures slv_rdata (reads), next state RESP.
REQ-028 SLOW: counter reaching TIMEOUT with slv_ack=0 -> ERR; slv_ack on the TIMEOUT cycle wins (RESP, no error).
REQ-029 Writes load cpu_rdata with 32'h0000_0000.
REQ-030 RESP: cpu_ready=1 for one cycle, bus_err=0; next state IDLE.
REQ-031 ERR: cpu_ready=1, bus_err=1 for one cycle, cpu_rdata=32'h0000_0000, err_count+1 saturating at 8'hFF; next state IDLE.
REQ-032 Total latency cpu_req-sampled to cpu_ready: FAST path FAST_LAT+2 cycles, DRAM path (cycles to ack)+2, unmapped 2.
REQ-033 cpu_req dropped mid-transaction: transaction completes and cpu_ready still pulses.
REQ-034 cpu_req sampled only in IDLE; back-to-back requests incur one IDLE cycle between cpu_ready and next strobe.
REQ-035 cpu_rdata holds its value until the next capture.

Reset
REQ-036 rst=1 at any time forces IDLE immediately; slv_stb, cpu_ready, bus_err = 0; slv_we = 0; slv_addr, slv_wdata, cpu_rdata = 0; err_count = 0; wait counter = 0.
REQ-037 A transaction interrupted by reset is discarded; no cpu_ready is issued for it.

Verification
REQ-038 Read addr 0x1000_0008, dec_fast=1, slv_rdata=0x0000_00A5, FAST_LAT=1 -> slv_stb 1 cycle, cpu_ready+rdata 0xA5 three cycles after request, bus_err=0.
REQ-039 Write 0x2000_0000 dec_dram, slv_ack after 5 cycles -> slv_stb high 5 cycles, slv_we=1, slv_wdata matches, cpu_ready with rdata 0.
REQ-040 DRAM read, no ack, TIMEOUT=16 -> stb 16 cycles, cpu_ready+bus_err together, err_count=1; repeat ack on 16th cycle -> no error.
REQ-041 Addr 0x1003_0000 dec_others -> no slv_stb, cpu_ready+bus_err after 2 cycles; 256 such accesses -> err_count stays 0xFF.
REQ-042 rst asserted during SLOW -> outputs zero at once, no cpu_ready; next request after rst release completes normally.
REQ-043 dec_fast and dec_dram both high -> SLOW path taken (waits for slv_ack).

Source files
------------

// File: rtl/io_bus_ctrl.sv
// io_bus_ctrl: single-master bus controller. It routes one CPU access at a
// time to fast on-chip targets (fixed latency), to DRAM (acknowledged) or to
// the error path (unmapped address). It returns read data with a
// one-cycle cpu_ready pulse and keeps a saturating bus error counter.
//
// Parameters
//   TIMEOUT   : maximum number of SLOW cycles spent waiting for slv_ack
//   FAST_LAT  : fixed strobe-to-capture latency for fast targets (1..15)
// Ports
//   clk_i / rst_i              : clock, asynchronous active-high reset
//   cpu_req_i, cpu_we_i        : CPU request and direction
//   cpu_addr_i, cpu_wdata_i    : CPU address and write data
//   dec_fast_i, dec_dram_i,
//   dec_others_i               : address decoder results
//   slv_stb_o, slv_we_o,
//   slv_addr_o, slv_wdata_o    : registered slave request
//   slv_rdata_i, slv_ack_i     : slave read data and DRAM acknowledge
//   cpu_rdata_o                : registered read data to the CPU
//   cpu_ready_o, bus_err_o     : completion and error pulses
//   err_count_o                : saturating bus error count
module io_bus_ctrl #(
    parameter int TIMEOUT  = 16,
    parameter int FAST_LAT = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        cpu_req_i,
    input  logic        cpu_we_i,
    input  logic [31:0] cpu_addr_i,
    input  logic [31:0] cpu_wdata_i,
    input  logic        dec_fast_i,
    input  logic        dec_dram_i,
    input  logic        dec_others_i,
    output logic        slv_stb_o,
    output logic        slv_we_o,
    output logic [31:0] slv_addr_o,
    output logic [31:0] slv_wdata_o,
    input  logic [31:0] slv_rdata_i,
    input  logic        slv_ack_i,
    output logic [31:0] cpu_rdata_o,
    output logic        cpu_ready_o,
    output logic        bus_err_o,
    output logic [7:0]  err_count_o
);

    localparam int CNT_MAX = (TIMEOUT > FAST_LAT) ? TIMEOUT : FAST_LAT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_FAST = 3'd1,
        S_SLOW = 3'd2,
        S_RESP = 3'd3,
        S_ERR  = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               latch_s;
    logic               capture_s;
    logic               slv_stb_q, slv_stb_d;
    logic               slv_we_q, slv_we_d;
    logic [31:0]        slv_addr_q, slv_addr_d;
    logic [31:0]        slv_wdata_q, slv_wdata_d;
    logic [31:0]        cpu_rdata_q, cpu_rdata_d;
    logic               cpu_ready_q, cpu_ready_d;
    logic               bus_err_q, bus_err_d;
    logic [7:0]         err_count_q, err_count_d;

    // Next-state logic and wait counter control.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        latch_s   = 1'b0;
        capture_s = 1'b0;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (cpu_req_i) begin
                    latch_s = 1'b1;
                    // No decode bit set is treated as unmapped.
                    if (dec_others_i || !(dec_dram_i || dec_fast_i)) begin
                        state_d = S_ERR;
                    end else if (dec_dram_i) begin
                        state_d = S_SLOW;
                        cnt_d   = CNT_W'(1);
                    end else begin
                        state_d = S_FAST;
                        cnt_d   = CNT_W'(1);
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_FAST: begin
                // cnt_q holds the 1-based index of the current FAST cycle.
                if (cnt_q >= CNT_W'(FAST_LAT)) begin
                    state_d   = S_RESP;
                    cnt_d     = '0;
                    capture_s = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_SLOW: begin
                // An ack on the final allowed cycle still completes normally.
                if (slv_ack_i) begin
                    state_d   = S_RESP;
                    cnt_d     = '0;
                    capture_s = 1'b1;
                end else if (cnt_q >= CNT_W'(TIMEOUT)) begin
                    state_d = S_ERR;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            S_ERR: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Datapath next values; outputs are pre-decoded from the next state so
    // they can be driven straight from flops.
    always_comb begin
        slv_we_d    = slv_we_q;
        slv_addr_d  = slv_addr_q;
        slv_wdata_d = slv_wdata_q;
        cpu_rdata_d = cpu_rdata_q;
        err_count_d = err_count_q;
        if (latch_s) begin
            slv_we_d    = cpu_we_i;
            slv_addr_d  = cpu_addr_i;
            slv_wdata_d = cpu_wdata_i;
        end else begin
            slv_we_d    = slv_we_q;
        end
        if (capture_s) begin
            cpu_rdata_d = slv_we_q ? 32'h0000_0000 : slv_rdata_i;
        end else if (state_d == S_ERR) begin
            cpu_rdata_d = 32'h0000_0000;
        end else begin
            cpu_rdata_d = cpu_rdata_q;
        end
        // ERR lasts exactly one cycle, so state_d == S_ERR marks its entry.
        if ((state_d == S_ERR) && (err_count_q != 8'hFF)) begin
            err_count_d = err_count_q + 8'd1;
        end else begin
            err_count_d = err_count_q;
        end
        slv_stb_d   = (state_d == S_FAST) || (state_d == S_SLOW);
        cpu_ready_d = (state_d == S_RESP) || (state_d == S_ERR);
        bus_err_d   = (state_d == S_ERR);
    end

    // State, counter and registered outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            slv_stb_q   <= 1'b0;
            slv_we_q    <= 1'b0;
            slv_addr_q  <= 32'h0000_0000;
            slv_wdata_q <= 32'h0000_0000;
            cpu_rdata_q <= 32'h0000_0000;
            cpu_ready_q <= 1'b0;
            bus_err_q   <= 1'b0;
            err_count_q <= 8'h00;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            slv_stb_q   <= slv_stb_d;
            slv_we_q    <= slv_we_d;
            slv_addr_q  <= slv_addr_d;
            slv_wdata_q <= slv_wdata_d;
            cpu_rdata_q <= cpu_rdata_d;
            cpu_ready_q <= cpu_ready_d;
            bus_err_q   <= bus_err_d;
            err_count_q <= err_count_d;
        end
    end

    assign slv_stb_o   = slv_stb_q;
    assign slv_we_o    = slv_we_q;
    assign slv_addr_o  = slv_addr_q;
    assign slv_wdata_o = slv_wdata_q;
    assign cpu_rdata_o = cpu_rdata_q;
    assign cpu_ready_o = cpu_ready_q;
    assign bus_err_o   = bus_err_q;
    assign err_count_o = err_count_q;

endmodule

// File: tb/tb_io_bus_ctrl.sv
// Self-checking bench for io_bus_ctrl: directed scenarios plus randomized
// transactions checked against a transaction-level reference model.
module tb_io_bus_ctrl;

    localparam int TIMEOUT  = 16;
    localparam int FAST_LAT = 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cpu_req = 1'b0;
    logic        cpu_we = 1'b0;
    logic [31:0] cpu_addr = 32'h0;
    logic [31:0] cpu_wdata = 32'h0;
    logic        dec_fast = 1'b0;
    logic        dec_dram = 1'b0;
    logic        dec_others = 1'b0;
    logic        slv_stb;
    logic        slv_we;
    logic [31:0] slv_addr;
    logic [31:0] slv_wdata;
    logic [31:0] slv_rdata = 32'h0;
    logic        slv_ack = 1'b0;
    logic [31:0] cpu_rdata;
    logic        cpu_ready;
    logic        bus_err;
    logic [7:0]  err_count;

    int checks = 0;
    int errors = 0;
    int exp_err_count = 0;
    logic [31:0] exp_rdata_last = 32'h0;

    io_bus_ctrl #(.TIMEOUT(TIMEOUT), .FAST_LAT(FAST_LAT)) dut (
        .clk_i(clk), .rst_i(rst),
        .cpu_req_i(cpu_req), .cpu_we_i(cpu_we),
        .cpu_addr_i(cpu_addr), .cpu_wdata_i(cpu_wdata),
        .dec_fast_i(dec_fast), .dec_dram_i(dec_dram), .dec_others_i(dec_others),
        .slv_stb_o(slv_stb), .slv_we_o(slv_we),
        .slv_addr_o(slv_addr), .slv_wdata_o(slv_wdata),
        .slv_rdata_i(slv_rdata), .slv_ack_i(slv_ack),
        .cpu_rdata_o(cpu_rdata), .cpu_ready_o(cpu_ready),
        .bus_err_o(bus_err), .err_count_o(err_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One CPU access, started in an IDLE cycle (called just after a negedge).
    // ack_after = index of the SLOW cycle that sees slv_ack (0 = never).
    task automatic run_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] rdata, input logic f, input logic d,
                           input logic o, input int ack_after, input logic drop_req);
        int exp_lat, exp_stb, k, stb_seen;
        logic exp_err;
        logic [31:0] exp_rd;
        bit done;
        // Reference model of the transaction outcome.
        if (o || !(f || d)) begin
            exp_lat = 2; exp_stb = 0; exp_err = 1'b1; exp_rd = 32'h0;
        end else if (d) begin
            if (ack_after >= 1 && ack_after <= TIMEOUT) begin
                exp_lat = ack_after + 2; exp_stb = ack_after; exp_err = 1'b0;
                exp_rd = we ? 32'h0 : rdata;
            end else begin
                exp_lat = TIMEOUT + 2; exp_stb = TIMEOUT; exp_err = 1'b1; exp_rd = 32'h0;
            end
        end else begin
            exp_lat = FAST_LAT + 2; exp_stb = FAST_LAT; exp_err = 1'b0;
            exp_rd = we ? 32'h0 : rdata;
        end
        if (exp_err && exp_err_count < 255) exp_err_count++;

        cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
        dec_fast = f; dec_dram = d; dec_others = o; slv_rdata = rdata; slv_ack = 1'b0;
        k = 1; stb_seen = 0; done = 0;
        while (!done && k < 64) begin
            @(negedge clk);
            k++;
            if (drop_req && k == 2) cpu_req = 1'b0;
            slv_ack = 1'b0;
            if (slv_stb) begin
                stb_seen++;
                chk("slv_we", {31'h0, slv_we}, {31'h0, we});
                chk("slv_addr", slv_addr, addr);
                chk("slv_wdata", slv_wdata, wdata);
                if (stb_seen == ack_after) slv_ack = 1'b1;
            end
            if (cpu_ready) done = 1;
        end
        chk("latency", k, exp_lat);
        chk("stb_cycles", stb_seen, exp_stb);
        chk("cpu_ready", {31'h0, cpu_ready}, 32'h1);
        chk("bus_err", {31'h0, bus_err}, {31'h0, exp_err});
        chk("cpu_rdata", cpu_rdata, exp_rd);
        chk("err_count", {24'h0, err_count}, exp_err_count);
        exp_rdata_last = exp_rd;
        cpu_req = 1'b0; slv_ack = 1'b0;
        @(negedge clk);
        // Idle gap after completion; read data must be held.
        chk("idle_stb", {31'h0, slv_stb}, 32'h0);
        chk("idle_ready", {31'h0, cpu_ready}, 32'h0);
        chk("rdata_hold", cpu_rdata, exp_rdata_last);
    endtask

    initial begin
        #1;
        chk("rst_stb", {31'h0, slv_stb}, 32'h0);
        chk("rst_ready", {31'h0, cpu_ready}, 32'h0);
        chk("rst_addr", slv_addr, 32'h0);
        chk("rst_rdata", cpu_rdata, 32'h0);
        chk("rst_errcnt", {24'h0, err_count}, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Fast read, fast write, DRAM write acked after 5, timeout, ack on 16th.
        run_txn(1'b0, 32'h1000_0008, 32'h0, 32'h0000_00A5, 1'b1, 1'b0, 1'b0, 0, 1'b0);
        run_txn(1'b1, 32'h1000_0010, 32'hCAFE_0001, 32'h1234_5678, 1'b1, 1'b0, 1'b0, 0, 1'b0);
        run_txn(1'b1, 32'h2000_0000, 32'hDEAD_BEEF, 32'h5555_AAAA, 1'b0, 1'b1, 1'b0, 5, 1'b0);
        run_txn(1'b0, 32'h2000_0040, 32'h0, 32'h7777_1111, 1'b0, 1'b1, 1'b0, 0, 1'b0);
        run_txn(1'b0, 32'h2000_0044, 32'h0, 32'h8888_2222, 1'b0, 1'b1, 1'b0, 16, 1'b0);
        // Both fast and dram decode: the DRAM path wins.
        run_txn(1'b0, 32'h2000_0048, 32'h0, 32'h0BAD_F00D, 1'b1, 1'b1, 1'b0, 3, 1'b0);
        // Unmapped, and no decode bit at all; request dropped early.
        run_txn(1'b0, 32'h1003_0000, 32'h0, 32'h1111_1111, 1'b0, 1'b0, 1'b1, 0, 1'b0);
        run_txn(1'b0, 32'h1004_0000, 32'h0, 32'h2222_2222, 1'b0, 1'b0, 1'b0, 0, 1'b1);
        run_txn(1'b0, 32'h2000_0050, 32'h0, 32'h3333_4444, 1'b0, 1'b1, 1'b0, 4, 1'b1);

        // Randomized traffic.
        for (int i = 0; i < 40; i++) begin
            int p;
            p = $urandom_range(0, 2);
            run_txn($urandom_range(0, 1) == 1, $urandom, $urandom, $urandom,
                    p == 0, p == 1, p == 2, $urandom_range(0, 20),
                    $urandom_range(0, 3) == 0);
        end

        // Reset in the middle of a DRAM access.
        run_txn(1'b0, 32'h1000_0000, 32'h0, 32'h00C0_FFEE, 1'b1, 1'b0, 1'b0, 0, 1'b0);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h2000_0100;
        dec_fast = 1'b0; dec_dram = 1'b1; dec_others = 1'b0;
        repeat (4) @(negedge clk);
        chk("pre_rst_stb", {31'h0, slv_stb}, 32'h1);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_stb", {31'h0, slv_stb}, 32'h0);
        chk("mid_rst_ready", {31'h0, cpu_ready}, 32'h0);
        chk("mid_rst_addr", slv_addr, 32'h0);
        chk("mid_rst_rdata", cpu_rdata, 32'h0);
        chk("mid_rst_errcnt", {24'h0, err_count}, 32'h0);
        exp_err_count = 0;
        cpu_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("post_rst_ready", {31'h0, cpu_ready}, 32'h0);
        end
        run_txn(1'b0, 32'h2000_0104, 32'h0, 32'h4242_4242, 1'b0, 1'b1, 1'b0, 2, 1'b0);

        // Saturation of the error counter.
        for (int i = 0; i < 258; i++) begin
            run_txn(1'b0, 32'h1003_0000, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 0, 1'b0);
        end
        chk("errcnt_sat", {24'h0, err_count}, 32'h0000_00FF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
